// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, deserializes 11-bit frames,
// checks odd parity and folds E0/F0 prefixes into a single key event.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                  state, state_n;
    logic                    clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0]   filt_sr;
    logic                    filt_clk;
    logic                    fall;
    logic [2:0]              bit_cnt;
    logic [7:0]              shreg;
    logic                    par_bit;
    logic [TW-1:0]           tmo_cnt;
    logic                    ext_flag, brk_flag;
    logic                    stop_fall, tmo_hit, frame_good;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_sr  <= '1;
            filt_clk <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            dat_s1  <= ps2_data;
            dat_s2  <= dat_s1;
            filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (&filt_sr)
                filt_clk <= 1'b1;
            else if (~|filt_sr)
                filt_clk <= 1'b0;
        end
    end

    // Asserted in the cycle the filtered clock is about to drop, so data is sampled with minimum lag.
    assign fall = filt_clk & ~|filt_sr;

    assign stop_fall  = (state == STOP) && fall;
    assign tmo_hit    = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT - 1));
    assign frame_good = dat_s2 & (^{shreg, par_bit});

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (fall && !dat_s2)         state_n = DATA;
            DATA:    if (fall && bit_cnt == 3'd7) state_n = PARITY;
            PARITY:  if (fall)                    state_n = STOP;
            STOP:    if (fall)                    state_n = IDLE;
            default:                              state_n = IDLE;
        endcase
        if (tmo_hit)
            state_n = IDLE;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;

            if (fall || state == IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (fall) begin
                unique case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= dat_s2;
                    default: ;
                endcase
            end

            // Prefix bytes only arm flags; any error or completed key consumes them.
            if (stop_fall) begin
                if (!frame_good) begin
                    frame_err <= 1'b1;
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end else if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    key_code  <= shreg;
                    key_ext   <= ext_flag;
                    key_break <= brk_flag;
                    key_valid <= 1'b1;
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end
            end else if (tmo_hit) begin
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frames are bit-banged on the raw lines and the expected
// key/error events, with their exact arrival cycle, are queued as the stop bit is driven.
module tb_ps2_keyboard_rx;

    localparam int FL   = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, frame_err;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .clkin     (clkin),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        int         at;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    // kind: 0 = no event, 1 = key_valid, 2 = frame_err expected after the stop bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_bit, input int kind,
                              input logic ext, input logic brk, output int last_fall);
        logic [10:0] bits;
        evt_t        e;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = ~(^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        last_fall = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                step(4);
                ps2_clk = 1'b0;
                step(3);
                ps2_clk = 1'b1;
                step(3);
            end else begin
                step(10);
            end
            ps2_clk   = 1'b0;
            last_fall = cyc;
            if (i == 10 && kind != 0) begin
                // Stop-bit fall appears 2+FL cycles after the raw edge; the pulse registers one later.
                e.is_err = (kind == 2);
                e.code   = b;
                e.ext    = ext;
                e.brk    = brk;
                e.at     = cyc + 3 + FL;
                exp_q.push_back(e);
            end
            step(HALF);
            ps2_clk = 1'b1;
            step(HALF - 10);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] b, input logic ext, input logic brk);
        int lf;
        send_frame(b, 1'b0, 1'b0, 11, -1, 1, ext, brk, lf);
    endtask

    always @(negedge clkin) begin
        evt_t e;
        if (!rst) begin
            if (key_valid || frame_err) begin
                check("valid_err_exclusive", 32'(key_valid & frame_err), 32'd0);
                if (key_valid) n_valid++;
                if (frame_err) n_err++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, key_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
                    check("pulse_cycle", cyc, e.at);
                    if (!e.is_err) begin
                        check("key_code", 32'(key_code), 32'(e.code));
                        check("key_ext", 32'(key_ext), 32'(e.ext));
                        check("key_break", 32'(key_break), 32'(e.brk));
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
                check("missing_pulse", cyc, exp_q[0].at);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lf;
        evt_t e;
        int w;

        step(3);
        @(negedge clkin);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_flags", {30'd0, key_ext, key_break}, 32'd0);
        step(1);
        rst = 1'b0;
        step(30);

        // Plain make code.
        send_key(8'h1C, 1'b0, 1'b0);

        // Extended break sequence, then the same code alone.
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1, 0, 1'b0, 1'b0, lf);
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 0, 1'b0, 1'b0, lf);
        send_key(8'h74, 1'b1, 1'b1);
        send_key(8'h74, 1'b0, 1'b0);

        // Parity error, then F0 wiped out by a bad stop bit.
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 2, 1'b0, 1'b0, lf);
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 0, 1'b0, 1'b0, lf);
        send_frame(8'h55, 1'b0, 1'b1, 11, -1, 2, 1'b0, 1'b0, lf);
        send_key(8'h1C, 1'b0, 1'b0);

        // Truncated frame: frame_err once the counter reaches TMO on the TMO-th edge after the last fall.
        send_frame(8'h1C, 1'b0, 1'b0, 5, -1, 0, 1'b0, 1'b0, lf);
        e.is_err = 1'b1;
        e.code   = 8'h00;
        e.ext    = 1'b0;
        e.brk    = 1'b0;
        e.at     = lf + 2 + FL + TMO + 1;
        exp_q.push_back(e);
        step(TMO + 60);
        send_key(8'h1C, 1'b0, 1'b0);

        // Short clock glitches in IDLE and mid-data must be filtered out.
        ps2_clk = 1'b0;
        step(3);
        ps2_clk = 1'b1;
        step(30);
        send_frame(8'h2B, 1'b0, 1'b0, 11, 4, 1, 1'b0, 1'b0, lf);

        // Reset after the 5th data bit discards the partial frame.
        send_frame(8'h33, 1'b0, 1'b0, 6, -1, 0, 1'b0, 1'b0, lf);
        rst = 1'b1;
        @(negedge clkin);
        check("midrst_key_code", 32'(key_code), 32'd0);
        check("midrst_pulses", {30'd0, key_valid, frame_err}, 32'd0);
        step(1);
        rst = 1'b0;
        step(30);
        send_key(8'h1C, 1'b0, 1'b0);

        w = 0;
        while (exp_q.size() > 0 && w < 500) begin
            step(1);
            w++;
        end
        step(20);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("valid_count", n_valid, 32'd7);
        check("err_count", n_err, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receive stage that consumes the divided keyboard clock. The divided clock is this block's `clkin`.
- Synchronizes and glitch-filters the raw PS/2 clock and data lines, deserializes 11-bit device-to-host frames and checks odd parity.
- Folds E0 (extended) and F0 (break) prefixes into a single key event, which downstream VGA/game logic consumes.

Parameters:
- FILTER_LEN, 8: number of consecutive identical synced `ps2_clk` samples required to change the filtered clock level; range 2..16.
- TIMEOUT, 50000: `clkin` cycles allowed between PS/2 falling edges inside a frame before the frame is aborted (1 ms at 50 MHz); counter width is $clog2(TIMEOUT+1).

Ports:
- clkin  in  1  divided system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard (asynchronous).
- ps2_data  in  1  raw PS/2 data from the keyboard (asynchronous).
- key_code  out  8  last completed non-prefix scan code.
- key_ext  out  1  key_code was preceded by E0.
- key_break  out  1  key_code was preceded by F0 (key release).
- key_valid  out  1  one-cycle pulse; key_code, key_ext and key_break are valid and stable until the next pulse.
- frame_err  out  1  one-cycle pulse on parity error, bad stop bit or timeout.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - Synchronizers to 1, filter shift register to all-ones, filtered clock to 1.
  - FSM to IDLE; bit counter, shift register, timeout counter and prefix flags cleared.
  - Reset mid-frame discards the partial frame with no pulse.
- Sync: 2-FF synchronizer on each of `ps2_clk` and `ps2_data`.
- Filter:
  - Shift register of FILTER_LEN synced clock samples.
  - Filtered clock goes 1 when all bits are 1, goes 0 when all bits are 0, otherwise holds.
- Edge: `fall` is asserted for exactly one cycle when the filtered clock goes 1→0. Synced data is sampled in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit) → DATA, bit count 0. On `fall` with data=1 → stay IDLE, no error.
  - DATA: on `fall`, shift data in LSB-first. After the 8th bit → PARITY.
  - PARITY: on `fall`, store the bit → STOP.
  - STOP: on `fall` → IDLE. The frame is good iff stop=1 and the XOR of the 8 data bits plus parity equals 1 (odd parity).
- Timeout:
  - The counter clears on every `fall` and in IDLE, and increments otherwise.
  - If it reaches TIMEOUT while not in IDLE: → IDLE, frame_err pulse, prefix flags cleared.
- Byte handling (registered, in the cycle after the STOP `fall`):
  - Good byte 0xE0: set ext flag, no pulse.
  - Good byte 0xF0: set break flag, no pulse.
  - Any other good byte: key_code=byte, key_ext=ext flag, key_break=break flag, key_valid=1 for one cycle, both flags cleared.
  - Bad frame: frame_err=1 for one cycle, byte discarded, flags cleared.
- Latency: key_valid/frame_err assert exactly 1 `clkin` cycle after the cycle in which the stop-bit `fall` is asserted. `fall` itself lags the raw edge by 2 (sync) + FILTER_LEN cycles.
- key_valid and frame_err are never asserted in the same cycle.
- A timeout and a `fall` in the same cycle: `fall` wins and the counter clears.
- Back-to-back frames need no idle gap beyond the stop bit.

Test Plan:
1. Send 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 10 kHz PS/2 clock → one key_valid pulse with key_code=0x1C, key_ext=0, key_break=0; frame_err never asserts.
2. Send E0, F0, 0x74 back-to-back → exactly one key_valid after the third frame, with key_code=0x74, key_ext=1, key_break=1. Then send 0x74 alone → key_ext=0, key_break=0.
3. Send 0x1C with parity=1 → frame_err pulses once, no key_valid. Then send F0 followed by a bad-stop-bit frame, then 0x1C → key_break=0 on the 0x1C event.
4. Send a start bit plus 4 data bits, then hold `ps2_clk` high → frame_err exactly TIMEOUT cycles after the last `fall`. A following 0x1C frame is received correctly.
5. Inject a 3-cycle low glitch on `ps2_clk` in IDLE and in mid-DATA (FILTER_LEN=8) → no `fall` generated, bit count unchanged, and the frame completes with the correct code.
6. Assert rst for 1 cycle after the 5th data bit, then send 0x1C → no pulse during reset, outputs 0, and the next key_valid carries 0x1C.
